// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   rx_state_e   : byte receiver states
//   word_state_e : word assembler / memory writer states
//   TERM_WORD_DEF: default end-of-program marker
package uart_loader_pkg;

  localparam logic [31:0] TERM_WORD_DEF = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    W_LOAD  = 2'd0,
    W_WRITE = 2'd1,
    W_DONE  = 2'd2
  } word_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchroniser.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   uart_rx_i     : asynchronous serial line, idle high
//   byte_o        : last received byte (valid with byte_valid_o)
//   byte_valid_o  : one-cycle pulse per byte with a good stop bit
//   frame_err_o   : sticky, set when a stop bit is sampled low
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // State registers; synchroniser resets to the idle-high level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Byte FSM: all samples are taken relative to the start-bit midpoint,
  // which leaves margin for a stretched start bit
  always_comb begin
    sync1_d = uart_rx_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;

    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          // line back high at the midpoint means a glitch, not a start bit
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: packs received bytes MSB first into 32-bit words and
// writes them to instruction RAM at consecutive addresses until the
// terminator word arrives.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   uart_rx_i      : serial input, idle high
//   mem_req_o/mem_gnt_i/mem_addr_o/mem_wdata_o : RAM write port
//   ready_o        : accepting program bytes
//   done_o         : load finished (sticky)
//   word_cnt_o     : words written
//   frame_err_o, overrun_err_o, overflow_err_o : sticky error flags
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned MEM_DEPTH    = 256,
  parameter logic [31:0] TERM_WORD    = TERM_WORD_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         uart_rx_i,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic                         ready_o,
  output logic                         done_o,
  output logic [$clog2(MEM_DEPTH):0]   word_cnt_o,
  output logic                         frame_err_o,
  output logic                         overrun_err_o,
  output logic                         overflow_err_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .uart_rx_i    (uart_rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (frame_err_o)
  );

  word_state_e   state_q, state_d;
  logic [23:0]   asm_q, asm_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          ovf_q, ovf_d;

  logic [31:0]   asm_word;
  logic          word_complete;
  logic [CW-1:0] cnt_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= W_LOAD;
      asm_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Word FSM; byte assembly keeps running while a write is pending
  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    ovf_d   = ovf_q;

    asm_word      = {asm_q, rx_byte};
    word_complete = rx_valid && (idx_q == 2'd3) && (state_q != W_DONE);
    cnt_inc       = cnt_q + CW'(1);

    if (rx_valid && (state_q != W_DONE)) begin
      asm_d = {asm_q[15:0], rx_byte};
      idx_d = idx_q + 2'd1;
    end

    unique case (state_q)
      W_LOAD: begin
        if (word_complete) begin
          if (asm_word == TERM_WORD) begin
            state_d = W_DONE;
            done_d  = 1'b1;
            ready_d = 1'b0;
          end else begin
            state_d = W_WRITE;
            req_d   = 1'b1;
            wdata_d = asm_word;
          end
        end
      end
      W_WRITE: begin
        // a new word finishing here is dropped, even if the grant lands now
        if (word_complete) begin
          ovr_d = 1'b1;
        end
        if (mem_gnt_i) begin
          req_d = 1'b0;
          cnt_d = cnt_inc;
          if (cnt_inc == DEPTH_C) begin
            // address saturates; memory full ends the load
            state_d = W_DONE;
            done_d  = 1'b1;
            ready_d = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = W_LOAD;
          end
        end
      end
      W_DONE: begin
      end
      default: state_d = W_LOAD;
    endcase
  end

  assign mem_req_o      = req_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign ready_o        = ready_q;
  assign done_o         = done_q;
  assign word_cnt_o     = cnt_q;
  assign overrun_err_o  = ovr_q;
  assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader. Uses a short bit time and a small
// memory so the overflow scenario stays within a modest run length.
module tb_uart_prog_loader;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          uart_rx_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          ready_o;
  logic          done_o;
  logic [AW:0]   word_cnt_o;
  logic          frame_err_o;
  logic          overrun_err_o;
  logic          overflow_err_o;

  uart_prog_loader #(
    .CLKS_PER_BIT (CPB),
    .MEM_DEPTH    (DEPTH),
    .TERM_WORD    (32'h0000_0FFF)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .uart_rx_i      (uart_rx_i),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .ready_o        (ready_o),
    .done_o         (done_o),
    .word_cnt_o     (word_cnt_o),
    .frame_err_o    (frame_err_o),
    .overrun_err_o  (overrun_err_o),
    .overflow_err_o (overflow_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // grant behaviour: 0 = always high, 1 = grant after 5 stall cycles, 2 = low
  int            gnt_mode = 0;
  int            stall    = 0;
  int            stable_err = 0;
  logic          hold_prev = 1'b0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Grant driver and write logger, evaluated on the falling edge
  initial begin
    mem_gnt_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (hold_prev && mem_req_o && (mem_addr_o !== last_addr || mem_wdata_o !== last_data))
        stable_err++;
      case (gnt_mode)
        0: mem_gnt_i = 1'b1;
        2: mem_gnt_i = 1'b0;
        default: begin
          if (mem_req_o) begin
            if (stall == 5) begin
              mem_gnt_i = 1'b1;
              stall = 0;
            end else begin
              mem_gnt_i = 1'b0;
              stall++;
            end
          end else begin
            mem_gnt_i = 1'b0;
            stall = 0;
          end
        end
      endcase
      if (mem_req_o && mem_gnt_i && !rst_i) begin
        wr_addr.push_back(mem_addr_o);
        wr_data.push_back(mem_wdata_o);
      end
      hold_prev = mem_req_o && !mem_gnt_i;
      last_addr = mem_addr_o;
      last_data = mem_wdata_o;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    wait_cycles(2);
    rst_i = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    stable_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stretch, input bit bad_stop);
    uart_rx_i = 1'b1;
    wait_cycles(2 * CPB);
    uart_rx_i = 1'b0;
    wait_cycles(CPB + stretch);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      wait_cycles(CPB);
    end
    uart_rx_i = ~bad_stop;
    wait_cycles(CPB);
    uart_rx_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int stretch);
    send_byte(w[31:24], stretch, 1'b0);
    send_byte(w[23:16], stretch, 1'b0);
    send_byte(w[15:8],  stretch, 1'b0);
    send_byte(w[7:0],   stretch, 1'b0);
    wait_cycles(6);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  32'(ready_o), 32'd1);
    check({tag, "_done"},   32'(done_o), 32'd0);
    check({tag, "_req"},    32'(mem_req_o), 32'd0);
    check({tag, "_addr"},   32'(mem_addr_o), 32'd0);
    check({tag, "_cnt"},    32'(word_cnt_o), 32'd0);
    check({tag, "_ferr"},   32'(frame_err_o), 32'd0);
    check({tag, "_ovr"},    32'(overrun_err_o), 32'd0);
    check({tag, "_ovf"},    32'(overflow_err_o), 32'd0);
  endtask

  initial begin
    rst_i     = 1'b1;
    uart_rx_i = 1'b1;
    wait_cycles(3);
    do_reset();
    wait_cycles(1);
    check_reset_vals("rst");

    // One word then terminator, start bit stretched by CPB/4, grant high
    gnt_mode = 0;
    send_word(32'hDEAD_BEEF, CPB / 4);
    send_word(32'h0000_0FFF, CPB / 4);
    check("t1_nwr",  32'(wr_data.size()), 32'd1);
    check("t1_addr", 32'(wr_addr[0]), 32'd0);
    check("t1_data", wr_data[0], 32'hDEAD_BEEF);
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_rdy",  32'(ready_o), 32'd0);
    check("t1_cnt",  32'(word_cnt_o), 32'd1);
    check("t1_errs", {29'd0, frame_err_o, overrun_err_o, overflow_err_o}, 32'd0);

    // Three words with a 5-cycle grant stall each
    do_reset();
    gnt_mode = 1;
    send_word(32'h0102_0304, 0);
    wait_cycles(10);
    send_word(32'h0506_0708, 0);
    wait_cycles(10);
    send_word(32'h090A_0B0C, 0);
    wait_cycles(10);
    send_word(32'h0000_0FFF, 0);
    check("t2_nwr",   32'(wr_data.size()), 32'd3);
    check("t2_a0",    32'(wr_addr[0]), 32'd0);
    check("t2_a1",    32'(wr_addr[1]), 32'd1);
    check("t2_a2",    32'(wr_addr[2]), 32'd2);
    check("t2_d0",    wr_data[0], 32'h0102_0304);
    check("t2_d2",    wr_data[2], 32'h090A_0B0C);
    check("t2_stable", 32'(stable_err), 32'd0);
    check("t2_cnt",   32'(word_cnt_o), 32'd3);
    check("t2_done",  32'(done_o), 32'd1);

    // Bad stop bit on the second byte: byte dropped, index unchanged
    do_reset();
    gnt_mode = 0;
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b1);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0);
    wait_cycles(6);
    check("t3_ferr", 32'(frame_err_o), 32'd1);
    check("t3_nwr",  32'(wr_data.size()), 32'd1);
    check("t3_data", wr_data[0], 32'h1133_4455);
    check("t3_ovr",  32'(overrun_err_o), 32'd0);
    check("t3_done", 32'(done_o), 32'd0);

    // Fill memory without a terminator
    do_reset();
    gnt_mode = 0;
    for (int i = 0; i < int'(DEPTH); i++) send_word(32'hA500_0000 + 32'(i), 0);
    check("t4_nwr",  32'(wr_data.size()), DEPTH);
    check("t4_alast", 32'(wr_addr[DEPTH-1]), DEPTH - 1);
    check("t4_dlast", wr_data[DEPTH-1], 32'hA500_0000 + DEPTH - 1);
    check("t4_ovf",  32'(overflow_err_o), 32'd1);
    check("t4_done", 32'(done_o), 32'd1);
    check("t4_cnt",  32'(word_cnt_o), DEPTH);
    check("t4_rdy",  32'(ready_o), 32'd0);
    send_word(32'h1234_5678, 0);
    check("t4_ignored", 32'(wr_data.size()), DEPTH);

    // Short low glitch: no byte, no error, byte index still 0
    do_reset();
    gnt_mode = 0;
    wait_cycles(4);
    uart_rx_i = 1'b0;
    wait_cycles(3);
    uart_rx_i = 1'b1;
    wait_cycles(20 * CPB);
    check("t5_ferr", 32'(frame_err_o), 32'd0);
    check("t5_nwr0", 32'(wr_data.size()), 32'd0);
    send_word(32'hCAFE_F00D, 0);
    check("t5_nwr",  32'(wr_data.size()), 32'd1);
    check("t5_data", wr_data[0], 32'hCAFE_F00D);

    // Grant held low across the next word: overrun
    gnt_mode = 2;
    send_word(32'h1234_5678, 0);
    check("t6_req",  32'(mem_req_o), 32'd1);
    check("t6_addr", 32'(mem_addr_o), 32'd1);
    send_word(32'h9ABC_DEF0, 0);
    check("t6_ovr",  32'(overrun_err_o), 32'd1);
    check("t6_hold", mem_wdata_o, 32'h1234_5678);
    gnt_mode = 0;
    wait_cycles(4);
    check("t6_nwr",  32'(wr_data.size()), 32'd2);
    check("t6_d1",   wr_data[1], 32'h1234_5678);
    check("t6_cnt",  32'(word_cnt_o), 32'd2);
    check("t6_req0", 32'(mem_req_o), 32'd0);

    // Reset after two bytes discards the partial word
    do_reset();
    gnt_mode = 0;
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    wait_cycles(4);
    do_reset();
    wait_cycles(1);
    check_reset_vals("t7");
    send_word(32'h1122_3344, 0);
    check("t7_nwr",  32'(wr_data.size()), 32'd1);
    check("t7_addr", 32'(wr_addr[0]), 32'd0);
    check("t7_data", wr_data[0], 32'h1122_3344);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

On-chip UART boot loader: the receiving end of the host's program download stream. Deserialises 8N1 UART bytes from `uart_rx_i` and packs every four bytes, MSB first, into a 32-bit word. Writes each word to instruction memory at consecutive word addresses and stops on the terminator word `32'h0000_0FFF`. Sits between the SoC UART pad and the instruction-RAM write port; `done_o` releases the core from reset.

## Interface
- `CLKS_PER_BIT`, 87: clock cycles per UART bit (10 MHz clock, 115200 baud); must be ≥ 8.
- `MEM_DEPTH`, 256: instruction-memory depth in 32-bit words.
- `TERM_WORD`, `32'h0000_0FFF`: end-of-program marker; never written to memory.
- `clk_i  in  1`: single clock.
- `rst_i  in  1`: reset, synchronous, active-high.
- `uart_rx_i  in  1`: asynchronous serial input, idle high.
- `mem_req_o  out  1`: write request to instruction RAM.
- `mem_gnt_i  in  1`: RAM accepts the request in any cycle where `mem_req_o && mem_gnt_i`.
- `mem_addr_o  out  $clog2(MEM_DEPTH)`: word address.
- `mem_wdata_o  out  32`: write data.
- `ready_o  out  1`: loader is accepting program bytes.
- `done_o  out  1`: load finished, sticky until reset.
- `word_cnt_o  out  $clog2(MEM_DEPTH)+1`: number of words written.
- `frame_err_o  out  1`: sticky; a stop bit was sampled low.
- `overrun_err_o  out  1`: sticky; a word completed while the previous write was still pending.
- `overflow_err_o  out  1`: sticky; `MEM_DEPTH` words were written without a terminator.

## Operation
- Reset values: `ready_o`=1. All other outputs are 0. Byte index = 0, address = 0.
- RX path:
  - `uart_rx_i` passes through a 2-flop synchroniser; latency is 2 cycles.
  - Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised falling edge.
  - START: resample at CLKS_PER_BIT/2. If the line is high, the start was a glitch; return to IDLE. If low, go to DATA.
  - DATA: sample 8 bits, LSB first, every CLKS_PER_BIT cycles, counting from the start-bit midpoint.
  - STOP: sample once. High emits a one-cycle `byte_valid` pulse. Low sets `frame_err_o`, drops the byte and leaves the byte index unchanged.
  - STOP→IDLE occurs right after the stop sample. There is no wait for the end of the stop bit.
- Start-bit tolerance: the host may stretch the start bit by up to CLKS_PER_BIT/4 cycles, and the receiver must still sample every data bit correctly.
- Word FSM states: LOAD, WRITE, DONE.
  - LOAD: byte k (0..3) goes into bits [31-8k -: 8]. On the 4th byte:
    - if the word equals TERM_WORD, go to DONE and issue no write;
    - otherwise assert `mem_req_o` with the current address and data, and go to WRITE.
  - WRITE: hold request, address and data stable until grant. On grant: address+1, `word_cnt_o`+1. Return to LOAD, or go to DONE with `overflow_err_o`=1 if the count reaches MEM_DEPTH.
  - A byte that arrives while in WRITE is still assembled.
  - A 4th byte completing while in WRITE sets `overrun_err_o` and drops the new word.
  - DONE: `done_o`=1, `ready_o`=0. Further RX bytes are ignored.
- Address and counter arithmetic:
  - Address is unsigned and never wraps; overflow terminates the load.
  - `word_cnt_o` is one bit wider than the address so it can represent MEM_DEPTH.

## Timing
- `byte_valid` occurs 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (±1) after the line's falling edge.
- `mem_req_o` rises in the cycle after the 4th `byte_valid`.
- `done_o` rises in the cycle after the terminator's 4th `byte_valid`, or in the cycle after the grant that hits MEM_DEPTH.
- A grant in the same cycle as the request rising completes the write in one cycle.
- `rst_i` mid-operation:
  - within one cycle, everything returns to reset values and `mem_req_o` drops;
  - the partial word and the pending write are discarded.
- Simultaneous grant and overrun byte: the write completes and the new word is dropped, with the error flagged.

## Structure
- Package `uart_loader_pkg`: RX-state and word-state enums, and the `TERM_WORD` default.
- Sub-module `uart_rx_byte`: synchroniser, byte FSM and bit counter. Outputs are `byte_o[7:0]`, `byte_valid_o` and `frame_err_o`.
- `uart_prog_loader` owns the word FSM, address, counter and the other error flags.

## Test plan
- Bytes DE AD BE EF, 00 00 0F FF with the host start bit stretched 1000 ns (CLKS_PER_BIT=87, 100 ns clock), grant always high → one write, addr 0, data `32'hDEADBEEF`. Then `done_o`=1, `word_cnt_o`=1 and no error flags.
- Three words with `mem_gnt_i` delayed 5 cycles each → request, address and data stable during the stall. Addresses 0, 1, 2 in order; `word_cnt_o`=3.
- Stop bit forced low on the 2nd byte → `frame_err_o`=1. The byte is dropped and the following 4 valid bytes form the word.
- 256 non-terminator words → 256 writes, then `overflow_err_o`=1, `done_o`=1, `word_cnt_o`=256.
- 200 ns low glitch on `uart_rx_i` → no byte and no error.
- Grant held low across the next word → `overrun_err_o`=1.
- `rst_i` pulsed after 2 bytes → outputs return to reset values. A fresh 4-byte word then writes to address 0.
